// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with private HI/LO registers.
// Define MDU_MULTICYCLE_EN for the multi-cycle busy sequence; otherwise mult/div commit at the start edge.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_MDU_A,
    input  logic [31:0] E_MDU_B,
    input  logic [3:0]  E_MDUop,
    input  logic        E_MDU_start,
    input  logic        E_MDUout_sel,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDU_out
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_MULT  = 4'b0001,
        OP_MULTU = 4'b0010,
        OP_DIV   = 4'b0011,
        OP_DIVU  = 4'b0100,
        OP_MTHI  = 4'b0101,
        OP_MTLO  = 4'b0110
    } mdu_op_e;

    mdu_op_e     op;
    logic        is_mul;
    logic        is_div;
    logic        is_signed;

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        neg_a, neg_b;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] mag_a, mag_b, divisor;
    logic [31:0] quot_u, rem_u;
    logic        div_zero;
    logic [31:0] res_hi, res_lo;

    assign op = mdu_op_e'(E_MDUop);

    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        case (op)
            OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            default:  ;
        endcase
    end

    // One multiplier serves both flavours: operands are sign- or zero-extended to 64 bits.
    // Division runs on magnitudes so the most-negative / -1 case stays well defined.
    always_comb begin
        neg_a    = is_signed & E_MDU_A[31];
        neg_b    = is_signed & E_MDU_B[31];
        ext_a    = {{32{neg_a}}, E_MDU_A};
        ext_b    = {{32{neg_b}}, E_MDU_B};
        prod     = ext_a * ext_b;
        mag_a    = neg_a ? -E_MDU_A : E_MDU_A;
        mag_b    = neg_b ? -E_MDU_B : E_MDU_B;
        div_zero = (E_MDU_B == '0);
        divisor  = div_zero ? 32'd1 : mag_b;
        quot_u   = mag_a / divisor;
        rem_u    = mag_a % divisor;
        res_hi   = hi_q;
        res_lo   = lo_q;
        if (is_mul) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (is_div && !div_zero) begin
            res_lo = (neg_a ^ neg_b) ? -quot_u : quot_u;
            res_hi = neg_a ? -rem_u : rem_u;
        end
    end

`ifdef MDU_MULTICYCLE_EN
    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_nx_q, hi_nx_d;
    logic [31:0] lo_nx_q, lo_nx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_nx_q <= '0;
            lo_nx_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_nx_q <= hi_nx_d;
            lo_nx_q <= lo_nx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_nx_d = hi_nx_q;
        lo_nx_d = lo_nx_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (E_MDU_start) begin
                    if (is_mul || is_div) begin
                        hi_nx_d = res_hi;
                        lo_nx_d = res_lo;
                        cnt_d   = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        state_d = S_BUSY;
                    end else if (op == OP_MTHI) begin
                        hi_d = E_MDU_A;
                    end else if (op == OP_MTLO) begin
                        lo_d = E_MDU_A;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = hi_nx_q;
                    lo_d    = lo_nx_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign E_MDU_busy = (state_q == S_BUSY);
`else
    logic unused_params;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (E_MDU_start) begin
            if (is_mul || is_div) begin
                hi_d = res_hi;
                lo_d = res_lo;
            end else if (op == OP_MTHI) begin
                hi_d = E_MDU_A;
            end else if (op == OP_MTLO) begin
                lo_d = E_MDU_A;
            end
        end
    end

    assign E_MDU_busy    = 1'b0;
    assign unused_params = (MULT_CYCLES == 0) ^ (DIV_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign E_MDU_out = E_MDUout_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu; expectations follow MDU_MULTICYCLE_EN when it is defined.
module tb_e_mdu;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [31:0] E_MDU_A;
    logic [31:0] E_MDU_B;
    logic [3:0]  E_MDUop;
    logic        E_MDU_start;
    logic        E_MDUout_sel;
    logic        E_MDU_busy;
    logic [31:0] E_MDU_out;

    int tests = 0;
    int fails = 0;

    e_mdu #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .E_MDU_A      (E_MDU_A),
        .E_MDU_B      (E_MDU_B),
        .E_MDUop      (E_MDUop),
        .E_MDU_start  (E_MDU_start),
        .E_MDUout_sel (E_MDUout_sel),
        .E_MDU_busy   (E_MDU_busy),
        .E_MDU_out    (E_MDU_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        E_MDUout_sel = 1'b0;
        #1;
        check({tag, "_hi"}, E_MDU_out, eh);
        E_MDUout_sel = 1'b1;
        #1;
        check({tag, "_lo"}, E_MDU_out, el);
    endtask

    // Called at a negedge; issues one start and checks busy length and the committed result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int unsigned n,
                          input logic [31:0] old_lo, input logic [31:0] eh, input logic [31:0] el);
        E_MDUop     = op;
        E_MDU_A     = a;
        E_MDU_B     = b;
        E_MDU_start = 1'b1;
        @(negedge clk);
        E_MDU_start = 1'b0;
        E_MDUop     = 4'b0000;
`ifdef MDU_MULTICYCLE_EN
        for (int unsigned i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'b0, E_MDU_busy}, 32'd1);
            if (i == 0) begin
                E_MDUout_sel = 1'b1;
                #1;
                check({tag, "_nopend"}, E_MDU_out, old_lo);
            end
            @(negedge clk);
        end
`else
        check({tag, "_nopend"}, {31'b0, (n == 0)}, 32'd0);
`endif
        check({tag, "_idle"}, {31'b0, E_MDU_busy}, 32'd0);
        check_hilo(tag, eh, el);
    endtask

    initial begin
        reset        = 1'b0;
        E_MDU_A      = '0;
        E_MDU_B      = '0;
        E_MDUop      = 4'b0000;
        E_MDU_start  = 1'b0;
        E_MDUout_sel = 1'b0;

        @(negedge clk);
        check("rst_busy", {31'b0, E_MDU_busy}, 32'd0);
        check_hilo("rst", 32'h0000_0000, 32'h0000_0000);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult",  4'b0001, 32'hFFFF_FFFE, 32'h0000_0003, MULT_N,
               32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N,
               32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("multmin", 4'b0001, 32'h8000_0000, 32'h8000_0000, MULT_N,
               32'h0000_0001, 32'h4000_0000, 32'h0000_0000);
        run_op("div",   4'b0011, 32'hFFFF_FFF9, 32'h0000_0002, DIV_N,
               32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 4'b0100, 32'h0000_0007, 32'h0000_0000, DIV_N,
               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divnb", 4'b0011, 32'h0000_0007, 32'hFFFF_FFFE, DIV_N,
               32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu",  4'b0100, 32'hFFFF_FFF9, 32'h0000_0002, DIV_N,
               32'hFFFF_FFFD, 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div0",  4'b0011, 32'h0000_0005, 32'h0000_0000, DIV_N,
               32'h7FFF_FFFC, 32'h0000_0001, 32'h7FFF_FFFC);

        E_MDUop     = 4'b0101;
        E_MDU_A     = 32'h1234_5678;
        E_MDU_start = 1'b1;
        @(negedge clk);
        check("mthi_busy", {31'b0, E_MDU_busy}, 32'd0);
        check_hilo("mthi", 32'h1234_5678, 32'h7FFF_FFFC);
        E_MDUop = 4'b0110;
        E_MDU_A = 32'h9ABC_DEF0;
        @(negedge clk);
        E_MDU_start = 1'b0;
        E_MDUop     = 4'b0000;
        check("mtlo_busy", {31'b0, E_MDU_busy}, 32'd0);
        check_hilo("mtlo", 32'h1234_5678, 32'h9ABC_DEF0);

        E_MDUop     = 4'b0111;
        E_MDU_A     = 32'hDEAD_BEEF;
        E_MDU_B     = 32'h0000_0001;
        E_MDU_start = 1'b1;
        @(negedge clk);
        E_MDU_start = 1'b0;
        E_MDUop     = 4'b0000;
        check("nop_busy", {31'b0, E_MDU_busy}, 32'd0);
        check_hilo("nop", 32'h1234_5678, 32'h9ABC_DEF0);

        E_MDUop     = 4'b0001;
        E_MDU_A     = 32'h0000_0006;
        E_MDU_B     = 32'h0000_0007;
        E_MDU_start = 1'b1;
        @(negedge clk);
        E_MDU_start = 1'b0;
        E_MDUop     = 4'b0000;
`ifdef MDU_MULTICYCLE_EN
        check("rmid_busy1", {31'b0, E_MDU_busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("rmid_busy3", {31'b0, E_MDU_busy}, 32'd1);
`else
        check("m42_busy", {31'b0, E_MDU_busy}, 32'd0);
        check_hilo("m42", 32'h0000_0000, 32'h0000_002A);
`endif
        reset = 1'b0;
        #1;
        check("rmid_busy", {31'b0, E_MDU_busy}, 32'd0);
        check_hilo("rmid", 32'h0000_0000, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b1;
        for (int unsigned i = 0; i < MULT_N + 3; i++) begin
            @(negedge clk);
            check("rpost_busy", {31'b0, E_MDU_busy}, 32'd0);
        end
        check_hilo("rpost", 32'h0000_0000, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
